// File: rtl/multicycle_sequencer_pkg.sv
// multicycle_sequencer_pkg: micro-op codes, sequencer states and reused opcodes
package multicycle_sequencer_pkg;
  localparam int CNT_W = 2;
  localparam logic [4:0] OP_LDM  = 5'h0A;
  localparam logic [4:0] OP_CALL = 5'h18;
  localparam logic [4:0] OP_RET  = 5'h19;
  localparam logic [4:0] OP_RTI  = 5'h1A;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_RDST = 2'b01;
  localparam logic [1:0] PC_POP  = 2'b10;
  localparam logic [1:0] PC_VEC  = 2'b11;
  typedef enum logic [3:0] {
    UOP_NONE     = 4'd0,
    UOP_LDM_IMM  = 4'd1,
    UOP_PUSH_PCL = 4'd2,
    UOP_PUSH_PCH = 4'd3,
    UOP_POP_PCH  = 4'd4,
    UOP_POP_PCL  = 4'd5,
    UOP_PUSH_FLG = 4'd6,
    UOP_POP_FLG  = 4'd7
  } uop_e;
  typedef enum logic [8:0] {
    SEQ_IDLE    = 9'b000000001,
    SEQ_LDM_IMM = 9'b000000010,
    SEQ_CALL_H  = 9'b000000100,
    SEQ_RET_L   = 9'b000001000,
    SEQ_RTI_H   = 9'b000010000,
    SEQ_RTI_L   = 9'b000100000,
    SEQ_INT_PCL = 9'b001000000,
    SEQ_INT_PCH = 9'b010000000,
    SEQ_FLUSH   = 9'b100000000
  } seq_state_e;
endpackage

// File: rtl/multicycle_sequencer_seq_flush_counter.sv
// seq_flush_counter: loadable down-counter of wrong-path slots, flags the final slot
module seq_flush_counter
  import multicycle_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_last
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_last = r_cnt == CNT_W'(1);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: decode-stage FSM stepping LDM, CALL, RET, RTI and interrupt entry
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int OPW        = 5,
  parameter int FLUSH_CALL = 1,
  parameter int FLUSH_RET  = 2,
  parameter int FLUSH_INT  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           dec_valid,
  input  logic           bubble,
  input  logic           int_req,
  output logic [3:0]     uop,
  output logic           stall_fetch,
  output logic           flush_dec,
  output logic [1:0]     pc_sel,
  output logic           pc_half,
  output logic           pc_load,
  output logic           int_ack,
  output logic           busy
);
  localparam seq_state_e S_AFTER_CALL = FLUSH_CALL == 0 ? SEQ_IDLE : SEQ_FLUSH;
  localparam seq_state_e S_AFTER_RET  = FLUSH_RET  == 0 ? SEQ_IDLE : SEQ_FLUSH;
  localparam seq_state_e S_AFTER_INT  = FLUSH_INT  == 0 ? SEQ_IDLE : SEQ_FLUSH;
  seq_state_e       r_state, w_next;
  uop_e             w_uop;
  logic             r_int_pend, w_load, w_dec, w_last;
  logic [CNT_W-1:0] w_load_val;
  seq_flush_counter u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .i_dec  (w_dec),
    .o_last (w_last)
  );
  always_comb begin
    w_next      = r_state;
    w_uop       = UOP_NONE;
    stall_fetch = 1'b0;
    flush_dec   = 1'b0;
    pc_sel      = PC_SEQ;
    pc_half     = 1'b0;
    pc_load     = 1'b0;
    int_ack     = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    // A hazard bubble freezes any in-flight step so it re-issues intact
    if (bubble && r_state != SEQ_IDLE && r_state != SEQ_FLUSH) stall_fetch = 1'b1;
    else begin
      unique case (r_state)
        SEQ_IDLE: if (!bubble) begin
          if (r_int_pend) begin
            w_uop = UOP_PUSH_FLG; flush_dec = 1'b1; stall_fetch = 1'b1; int_ack = 1'b1;
            w_next = SEQ_INT_PCL;
          end else if (dec_valid) begin
            if (opcode == OPW'(OP_LDM)) w_next = SEQ_LDM_IMM;
            else if (opcode == OPW'(OP_CALL)) begin
              w_uop = UOP_PUSH_PCL; stall_fetch = 1'b1; w_next = SEQ_CALL_H;
            end else if (opcode == OPW'(OP_RET)) begin
              w_uop = UOP_POP_PCH; stall_fetch = 1'b1; pc_sel = PC_POP; pc_half = 1'b1;
              pc_load = 1'b1; w_next = SEQ_RET_L;
            end else if (opcode == OPW'(OP_RTI)) begin
              w_uop = UOP_POP_FLG; stall_fetch = 1'b1; w_next = SEQ_RTI_H;
            end
          end
        end
        SEQ_LDM_IMM: begin
          w_uop = UOP_LDM_IMM; w_next = SEQ_IDLE;
        end
        SEQ_CALL_H: begin
          w_uop = UOP_PUSH_PCH; pc_sel = PC_RDST; pc_load = 1'b1;
          w_load = 1'b1; w_load_val = CNT_W'(FLUSH_CALL); w_next = S_AFTER_CALL;
        end
        SEQ_RET_L, SEQ_RTI_L: begin
          w_uop = UOP_POP_PCL; pc_sel = PC_POP; pc_load = 1'b1;
          w_load = 1'b1; w_load_val = CNT_W'(FLUSH_RET); w_next = S_AFTER_RET;
        end
        SEQ_RTI_H: begin
          w_uop = UOP_POP_PCH; pc_sel = PC_POP; pc_half = 1'b1; pc_load = 1'b1;
          stall_fetch = 1'b1; w_next = SEQ_RTI_L;
        end
        SEQ_INT_PCL: begin
          w_uop = UOP_PUSH_PCL; stall_fetch = 1'b1; w_next = SEQ_INT_PCH;
        end
        SEQ_INT_PCH: begin
          w_uop = UOP_PUSH_PCH; pc_sel = PC_VEC; pc_load = 1'b1;
          w_load = 1'b1; w_load_val = CNT_W'(FLUSH_INT); w_next = S_AFTER_INT;
        end
        SEQ_FLUSH: begin
          flush_dec = 1'b1; w_dec = 1'b1; w_next = w_last ? SEQ_IDLE : SEQ_FLUSH;
        end
        default: w_next = SEQ_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SEQ_IDLE;
      r_int_pend <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_int_pend <= int_ack ? 1'b0 : (r_int_pend | int_req);
    end
  end
  assign uop  = w_uop;
  assign busy = r_state != SEQ_IDLE;
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- FSM that sequences every multi-cycle operation in the decode stage: LDM, CALL, RET, RTI and the external interrupt entry.
- It replaces the per-buffer St/Sst/firstTimeCall/firstTimeRET/FlushNum handshake registers with one owned state machine.
- It sits beside the control unit in decode. It emits a micro-op code that selects the control word, plus fetch-stall, decode-flush and PC-select controls.

Parameters:
- OPW, 5, opcode width
- FLUSH_CALL, 1, wrong-path slots killed after CALL redirect
- FLUSH_RET, 2, slots killed after RET/RTI redirect
- FLUSH_INT, 2, slots killed after interrupt vector load

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPW  opcode of instruction in decode slot
- dec_valid  in  1  decode slot holds a real instruction
- bubble  in  1  hazard-unit stall request
- int_req  in  1  external interrupt, level
- uop  out  4  micro-op selecting control word (codes below)
- stall_fetch  out  1  hold PC and IF/ID
- flush_dec  out  1  convert current decode slot to NOP
- pc_sel  out  2  00 sequential, 01 Rdst (call target), 10 popped word, 11 interrupt vector
- pc_half  out  1  with pc_sel=10: 1 loads PC high half, 0 loads low half
- pc_load  out  1  apply pc_sel this cycle
- int_ack  out  1  one-cycle pulse when interrupt sequence starts
- busy  out  1  FSM not in IDLE

Behaviour:
- uop codes: NONE=0, LDM_IMM=1, PUSH_PCL=2, PUSH_PCH=3, POP_PCH=4, POP_PCL=5, PUSH_FLG=6, POP_FLG=7.
- NONE means the control unit decodes the opcode normally.
- Reset: state=IDLE, flush counter=0, int_pend=0. All outputs 0, uop=NONE.
- int_pend: set when int_req=1. Cleared only when the interrupt sequence starts.
- IDLE with bubble=1: no transition, no opcode accepted, all outputs 0, uop=NONE.
- IDLE, no bubble, int_pend=1:
  - Interrupt wins over the decode opcode. The decode instruction is killed and replayed after RTI.
  - Outputs: flush_dec=1, stall_fetch=1, uop=PUSH_FLG, int_ack=1. Next state INT_PCL.
- IDLE, dec_valid=1, opcode:
  - LDM: uop=NONE (control unit issues NOP); next LDM_IMM.
  - CALL: uop=PUSH_PCL, stall_fetch=1; next CALL_H.
  - RET: uop=POP_PCH, stall_fetch=1, pc_sel=10, pc_half=1, pc_load=1; next RET_L.
  - RTI: uop=POP_FLG, stall_fetch=1; next RTI_H.
  - Any other opcode: uop=NONE, stay IDLE.
- LDM_IMM: the fetched word is the immediate. uop=LDM_IMM, no stall, no flush. Next IDLE.
- CALL_H: uop=PUSH_PCH, pc_sel=01, pc_load=1. Load counter=FLUSH_CALL; next FLUSH.
- RET_L and RTI_L: uop=POP_PCL, pc_sel=10, pc_half=0, pc_load=1. Load counter=FLUSH_RET; next FLUSH.
- RTI_H: uop=POP_PCH, pc_sel=10, pc_half=1, pc_load=1, stall_fetch=1. Next RTI_L.
- INT_PCL: uop=PUSH_PCL, stall_fetch=1. Next INT_PCH.
- INT_PCH: uop=PUSH_PCH, pc_sel=11, pc_load=1. Load counter=FLUSH_INT; next FLUSH.
- FLUSH:
  - Outputs: flush_dec=1, uop=NONE, stall_fetch=0.
  - Counter decrements each cycle; when counter==1 go to IDLE.
  - A counter value of 0 on entry (parameter 0) skips FLUSH and goes straight to IDLE.
- bubble=1 in any non-IDLE state except FLUSH:
  - The state is frozen, uop forced NONE, pc_load=0, stall_fetch=1.
  - The same step re-issues next cycle.
- bubble in FLUSH is ignored; the counter still decrements.
- int_req during a sequence only sets int_pend. It is taken on the first eligible IDLE cycle, after LDM_IMM and after the flush completes.
- The opcode input is ignored in every non-IDLE state.
- busy=1 exactly when state != IDLE.
- rst mid-sequence returns IDLE next edge, discarding the partial sequence; no pop/push completes.

Decomposition:
- defines.v gains the UOP_* codes and SEQ_* state encodings (one-hot, 9 states).
- The opcodes OP_LDM, OP_Call, OP_Ret and OP_RTI are reused from defines.v.
- One sub-module, seq_flush_counter: 2-bit loadable down-counter with a load input, a load value and a last-cycle flag.

Test Plan:
- LDM opcode with dec_valid=1 at cycle 0:
  - cycle0 uop=0, busy=0.
  - cycle1 uop=1, busy=1, stall_fetch=0.
  - cycle2 back to IDLE.
- CALL:
  - uop sequence 2,3; stall_fetch 1,0.
  - pc_load=1 with pc_sel=01 in cycle1.
  - flush_dec=1 for exactly 1 cycle (cycle2), IDLE at cycle3.
- RTI:
  - uop sequence 7,4,5.
  - pc_half 1 then 0 with pc_sel=10.
  - flush_dec=1 for cycles 3–4, busy low at cycle5.
- int_req pulse during a RET sequence:
  - No int_ack until the flush ends.
  - Then int_ack=1, uop 6,2,3, pc_sel=11 on the third step, 2 flush cycles.
- bubble=1 in CALL_H for 2 cycles:
  - uop=0, pc_load=0, stall_fetch=1 both cycles.
  - uop=3 with pc_load=1 on the cycle bubble drops.
- rst=1 in RET_L:
  - Next cycle all outputs 0, busy=0, int_pend cleared.
  - A following LDM sequences normally.
